// File: rtl/handshake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_pkg
//  Description : Shared types and constants for the handshake sequence sink:
//                run-state encoding, counter width and stall-LFSR constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package handshake_pkg;

    // Run-state encoding for the sink controller
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the beat and error counters
    localparam int CNT_W = 16;

    // Stall LFSR: reset seed and Fibonacci tap mask (taps 16,14,13,11)
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

endpackage : handshake_pkg
`default_nettype wire

// File: rtl/handshake_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_lfsr16
//  Description : 16-bit Fibonacci LFSR, advancing every cycle, used as a
//                pseudo-random backpressure source.
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_lfsr16
    import handshake_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] r_q;

    // Shift left each cycle, feeding back the XOR of the tapped bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= c_lfsr_seed;
        end else begin
            r_q <= {r_q[14:0], ^(r_q & c_lfsr_taps)};
        end
    end

    assign q = r_q;

endmodule : handshake_lfsr16
`default_nettype wire

// File: rtl/handshake_seq_sink.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_seq_sink
//  Description : Valid/ready sink that accepts NUM_BEATS transfers per run and
//                checks them against an incrementing sequence starting at
//                START_VAL, counting beats and mismatches.
//                Build option HANDSHAKE_SEQ_SINK_LFSR_STALL_EN replaces the
//                stall_i backpressure input with an internal LFSR source.
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_seq_sink
    import handshake_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_BEATS = 200,
    parameter int START_VAL = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  beat_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic              err_o,
    output logic [DATA_W-1:0] last_bad_o
);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_stall_src;
    logic               w_xfer;
    logic               w_last_beat;
    logic               w_enter_run;
    logic               r_ready;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               r_err;
    logic [DATA_W-1:0]  r_last_bad;
    logic [DATA_W-1:0]  r_expected;

`ifdef HANDSHAKE_SEQ_SINK_LFSR_STALL_EN
    logic [15:0] w_lfsr_q;

    handshake_lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr_q)
    );

    // stall_i is deliberately unused in this build
    assign w_stall_src = w_lfsr_q[0] & w_lfsr_q[3];
`else
    assign w_stall_src = stall_i;
`endif

    assign w_xfer      = valid_i & r_ready;
    assign w_last_beat = (r_beat_cnt == CNT_W'(NUM_BEATS - 1));
    assign w_enter_run = (r_state != RUN) && (w_next_state == RUN);

    // Next-state decode: start launches a run, the final transfer ends it
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start_i) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_xfer && w_last_beat) begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ready looks ahead at the next state so it drops on the final-beat edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_next_state == RUN) && !w_stall_src;
        end
    end

    // Sequence checker: clear on run entry, advance and compare per transfer
    always_ff @(posedge clk) begin
        if (rst || w_enter_run) begin
            r_beat_cnt <= '0;
            r_err_cnt  <= '0;
            r_err      <= 1'b0;
            r_last_bad <= '0;
            r_expected <= DATA_W'(START_VAL);
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            // Expected advances from its own value even after a mismatch
            r_expected <= r_expected + 1'b1;
            if (data_i != r_expected) begin
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                r_err      <= 1'b1;
                r_last_bad <= data_i;
            end
        end
    end

    assign ready_o    = r_ready;
    assign done_o     = (r_state == DONE);
    assign beat_cnt_o = r_beat_cnt;
    assign err_cnt_o  = r_err_cnt;
    assign err_o      = r_err;
    assign last_bad_o = r_last_bad;

endmodule : handshake_seq_sink
`default_nettype wire

// File: tb/tb_handshake_seq_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_handshake_seq_sink
//  Description : Self-checking bench for handshake_seq_sink with a cycle-level
//                behavioural model; NUM_BEATS=300 so the 8-bit stream wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_seq_sink;

    localparam int DW = 8;
    localparam int NB = 300;
    localparam int SV = 1;
    localparam int MOD = 1 << DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          stall_i;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          done_o;
    logic [15:0]   beat_cnt_o;
    logic [15:0]   err_cnt_o;
    logic          err_o;
    logic [DW-1:0] last_bad_o;

    always #5 clk = ~clk;

    handshake_seq_sink #(
        .DATA_W    (DW),
        .NUM_BEATS (NB),
        .START_VAL (SV)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .stall_i    (stall_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .beat_cnt_o (beat_cnt_o),
        .err_cnt_o  (err_cnt_o),
        .err_o      (err_o),
        .last_bad_o (last_bad_o)
    );

    // Model: mode 0 = idle, 1 = running, 2 = finished
    int m_mode     = 0;
    bit m_ready    = 0;
    int m_beats    = 0;
    int m_errs     = 0;
    bit m_err      = 0;
    int m_last_bad = 0;
    bit m_xfer     = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int sent  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model from the sampled inputs, then compare
    task automatic step();
        int want;
        @(posedge clk);
        m_xfer = 0;
        if (rst) begin
            m_mode = 0; m_ready = 0; m_beats = 0; m_errs = 0; m_err = 0; m_last_bad = 0;
        end else if (m_mode != 1) begin
            if (start_i) begin
                m_mode = 1; m_beats = 0; m_errs = 0; m_err = 0; m_last_bad = 0;
                m_ready = !stall_i;
            end else begin
                m_ready = 0;
            end
        end else begin
            if (valid_i && m_ready) begin
                m_xfer = 1;
                want = (SV + m_beats) % MOD;
                if (int'(data_i) != want) begin
                    if (m_errs < 65535) m_errs++;
                    m_err = 1;
                    m_last_bad = int'(data_i);
                end
                m_beats++;
            end
            if (m_beats == NB) begin
                m_mode = 2; m_ready = 0;
            end else begin
                m_ready = !stall_i;
            end
        end
        #1;
        check("ready_o",    {31'd0, ready_o},   {31'd0, m_ready});
        check("done_o",     {31'd0, done_o},    (m_mode == 2) ? 32'd1 : 32'd0);
        check("beat_cnt_o", {16'd0, beat_cnt_o}, m_beats);
        check("err_cnt_o",  {16'd0, err_cnt_o},  m_errs);
        check("err_o",      {31'd0, err_o},     {31'd0, m_err});
        check("last_bad_o", {24'd0, last_bad_o}, m_last_bad);
    endtask

    // Drive one cycle of upstream traffic; data follows the sequence unless
    // the index matches bad_idx, in which case bad_val is sent instead
    task automatic drive(input bit v, input bit s, input bit st, input int bad_idx, input int bad_val);
        int prev_mode;
        prev_mode = m_mode;
        valid_i = v;
        stall_i = s;
        start_i = st;
        if (v) data_i = (sent == bad_idx) ? DW'(bad_val) : DW'((SV + sent) % MOD);
        else   data_i = DW'($urandom);
        step();
        if (m_xfer) sent++;
        if (rst || (m_mode == 1 && prev_mode != 1)) sent = 0;
    endtask

    // Start pulse then stream until the model reports the run finished
    task automatic run_stream(input int stall_mode, input int bad_idx, input int bad_val,
                              input int budget, output int cycles);
        bit s;
        drive(1'b0, 1'b0, 1'b1, -1, 0);
        cycles = 1;
        while (m_mode != 2 && cycles < budget) begin
            case (stall_mode)
                1:       s = (cycles % 2) == 1;
                2:       s = ($urandom_range(99) < 30);
                default: s = 1'b0;
            endcase
            drive(1'b1, s, 1'b0, bad_idx, bad_val);
            cycles++;
        end
        check("run_reaches_done", {31'd0, done_o}, 32'd1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0; data_i = '0;
        drive(1'b0, 1'b0, 1'b0, -1, 0);
        drive(1'b0, 1'b0, 1'b0, -1, 0);
        rst = 1'b0;
        check("reset_ready", {31'd0, ready_o}, 32'd0);
        check("reset_done",  {31'd0, done_o},  32'd0);
        check("reset_beats", {16'd0, beat_cnt_o}, 32'd0);
        check("reset_errs",  {16'd0, err_cnt_o},  32'd0);

        // Continuous clean stream, crossing the 255 -> 0 wrap
        run_stream(0, -1, 0, NB + 20, cyc);
        check("clean_cycles", cyc, NB + 1);
        check("clean_beats",  {16'd0, beat_cnt_o}, NB);
        check("clean_errs",   {16'd0, err_cnt_o},  32'd0);
        check("clean_err",    {31'd0, err_o},      32'd0);
        check("clean_ready",  {31'd0, ready_o},    32'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, -1, 0);

        // Stall toggling every cycle: one transfer per two cycles
        run_stream(1, -1, 0, 2 * NB + 20, cyc);
        check("toggle_cycles", cyc, 2 * NB);
        check("toggle_errs",   {16'd0, err_cnt_o}, 32'd0);

        // Value 7 (index 6) replaced by 99; beat 8 still matches afterwards
        run_stream(0, 6, 99, NB + 20, cyc);
        check("inject_errs",     {16'd0, err_cnt_o},  32'd1);
        check("inject_err",      {31'd0, err_o},      32'd1);
        check("inject_last_bad", {24'd0, last_bad_o}, 32'd99);
        check("inject_beats",    {16'd0, beat_cnt_o}, NB);

        // Reset after 50 transfers aborts the run with nothing partial counted
        drive(1'b0, 1'b0, 1'b1, -1, 0);
        cyc = 0;
        while (sent < 50 && cyc < 200) begin
            drive(1'b1, 1'b0, 1'b0, -1, 0);
            cyc++;
        end
        check("midrun_beats", {16'd0, beat_cnt_o}, 32'd50);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, -1, 0);
        rst = 1'b0;
        check("abort_ready",    {31'd0, ready_o},    32'd0);
        check("abort_done",     {31'd0, done_o},     32'd0);
        check("abort_beats",    {16'd0, beat_cnt_o}, 32'd0);
        check("abort_err",      {31'd0, err_o},      32'd0);
        check("abort_last_bad", {24'd0, last_bad_o}, 32'd0);
        run_stream(0, -1, 0, NB + 20, cyc);
        check("after_abort_cycles", cyc, NB + 1);
        check("after_abort_errs",   {16'd0, err_cnt_o}, 32'd0);

        // valid held high through DONE, then a one-cycle start
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, -1, 0);
        check("done_hold_beats", {16'd0, beat_cnt_o}, NB);
        valid_i = 1'b1;
        drive(1'b1, 1'b0, 1'b1, -1, 0);
        check("restart_beats_zero", {16'd0, beat_cnt_o}, 32'd0);
        cyc = 0;
        while (m_mode != 2 && cyc < NB + 20) begin
            drive(1'b1, 1'b0, 1'b0, -1, 0);
            cyc++;
        end
        check("restart_transfers", sent, NB);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, -1, 0);
        check("no_extra_transfers", {16'd0, beat_cnt_o}, NB);

        // Randomized traffic: stalls, gaps, bad data, stray starts, resets
        for (int i = 0; i < 4000; i++) begin
            bit v, s, st;
            int bad;
            rst = ($urandom_range(999) < 3);
            v   = ($urandom_range(99) < 70);
            s   = ($urandom_range(99) < 30);
            st  = ($urandom_range(99) < 2) || (m_mode != 1 && $urandom_range(99) < 20);
            bad = ($urandom_range(99) < 10) ? sent : -1;
            drive(v, s, st, bad, int'($urandom_range(MOD - 1)));
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_handshake_seq_sink
`default_nettype wire

// File: doc/handshake_seq_sink.md
HANDSHAKE_SEQ_SINK -- requirements
Module: handshake_seq_sink

Interface
- REQ-001 Clocking: one clock; reset is synchronous and active-high.
- REQ-002 Parameter DATA_W, default 8: payload width.
- REQ-003 Parameter NUM_BEATS, default 200: transfers per run (1..65535).
- REQ-004 Parameter START_VAL, default 1: first expected payload value.
- REQ-005 Port clk, input, 1: rising-edge clock.
- REQ-006 Port rst, input, 1: synchronous active-high reset.
- REQ-007 Port start_i, input, 1: begin a run; sampled in IDLE and DONE only.
- REQ-008 Port stall_i, input, 1: external backpressure request; 1 means withhold ready next cycle.
- REQ-009 Port valid_i, input, 1: upstream valid.
- REQ-010 Port data_i, input, DATA_W: upstream payload.
- REQ-011 Port ready_o, output, 1: registered ready to upstream.
- REQ-012 Port done_o, output, 1: high while in DONE.
- REQ-013 Port beat_cnt_o, output, 16: accepted transfers in the current run.
- REQ-014 Port err_cnt_o, output, 16: mismatching transfers in the current run; saturates at 16'hFFFF.
- REQ-015 Port err_o, output, 1: sticky flag, set on any mismatch in the run.
- REQ-016 Port last_bad_o, output, DATA_W: payload of the most recent mismatching transfer.

Function
- REQ-017 The state machine SHALL have states IDLE, RUN and DONE.
- REQ-018 IDLE to RUN: start_i=1. DONE to RUN: start_i=1. RUN to DONE: accepted transfer while beat_cnt_o==NUM_BEATS-1.
- REQ-019 Transfer condition: valid_i && ready_o on a rising edge. No other condition counts as a transfer.
- REQ-020 ready_o SHALL be a flop. Its next value is 1 only when the next state is RUN and the stall source is 0. It is 0 in IDLE and DONE.
- REQ-021 ready_o SHALL fall in the same edge that takes the final transfer, so no transfer is accepted beyond NUM_BEATS.
- REQ-022 Entering RUN SHALL clear beat_cnt_o, err_cnt_o, err_o and last_bad_o, and set expected to START_VAL.
- REQ-023 On each transfer: expected increments modulo 2^DATA_W (255 wraps to 0), and beat_cnt_o increments.
- REQ-024 On a transfer with data_i != expected: err_cnt_o increments (saturating), err_o is set, last_bad_o is loaded with data_i, and expected still advances from its own value (no resync to data_i).
- REQ-025 valid_i while ready_o=0 SHALL have no effect. data_i is ignored when valid_i=0.
- REQ-026 start_i while in RUN SHALL be ignored.
- REQ-027 done_o SHALL be combinational from state (state==DONE). Counters hold their values in DONE until the next start.

Reset
- REQ-028 rst=1 at a rising edge SHALL force IDLE and clear ready_o, done_o, beat_cnt_o, err_cnt_o, err_o and last_bad_o. Expected is set to START_VAL.
- REQ-029 Reset asserted mid-RUN SHALL abort the run immediately. The next cycle shows ready_o=0 with no partial transfer counted.
- REQ-030 The LFSR (when built) SHALL reset to seed 16'hACE1.

Configuration
- REQ-031 Macro HANDSHAKE_SEQ_SINK_LFSR_STALL_EN selects the stall source.
- REQ-032 When the macro is defined: stall source = lfsr[0] & lfsr[3] from an internal 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every cycle. stall_i is present but ignored.
- REQ-033 When the macro is undefined: stall source = stall_i, and no LFSR logic is built.

Structure
- REQ-034 Package handshake_pkg SHALL hold the state enum (IDLE, RUN, DONE), the LFSR seed and taps constants, and the counter width constant CNT_W=16.
- REQ-035 Sub-module handshake_lfsr16 (clk, rst, q[15:0]) SHALL be instantiated only under the macro.

Verification
- REQ-036 Reset then start_i pulse, stall=0, upstream sends 1..200 continuously -> 200 transfers in 200 cycles, done_o=1, err_cnt_o=0, err_o=0, ready_o=0 afterwards.
- REQ-037 Same stream with stall_i toggling every cycle -> ready_o alternates; 200 transfers in about 400 cycles; err_cnt_o=0.
- REQ-038 Value 7 replaced by 99 in the stream -> err_cnt_o=1, err_o=1, last_bad_o=99; the next beat 8 is accepted without error.
- REQ-039 NUM_BEATS=300, DATA_W=8, stream wraps 255 to 0 -> err_cnt_o=0 and beat_cnt_o=300.
- REQ-040 rst asserted after 50 transfers -> next cycle is IDLE with all outputs 0. A new start followed by 1..200 passes cleanly.
- REQ-041 valid_i held high after DONE with start_i held high for one cycle -> exactly 200 further transfers and the counters restart from 0.
